bram_portb_arbiter: RTL and testbench
=====================================

// Module: bram_portb_arbiter
// PURPOSE
//   Shares the second port (port B) of the 16-bit unified BRAM between two requesters:
//   the VGA scanout reader and an auxiliary master (phone-input capture / debug DMA).
//   The VGA reader has priority; a starvation guard and a bounded lock keep the aux master
//   serviced. Sits between the vga/aux masters and bram port B (addr_b, data_b, we_b, q_b).
// PARAMETERS
//   ADDR_W        16  address width, matches bram addr_b
//   DATA_W        16  data width, matches bram data/q
//   RD_LATENCY    1   cycles from the granted address being presented to q_b valid (1..3)
//   STARVE_LIMIT  8   consecutive denied aux cycles before one forced aux grant (>=1)
//   LOCK_MAX      4   maximum consecutive aux grants while aux_lock is held (>=1)
// PORTS
//   clk          in   1       system clock
//   rst          in   1       asynchronous reset, active-high
//   vga_req      in   1       VGA read request, this cycle
//   vga_addr     in   ADDR_W  VGA read address
//   vga_gnt      out  1       VGA request accepted this cycle (combinational)
//   vga_rvalid   out  1       vga_rdata valid
//   vga_rdata    out  DATA_W  VGA read data
//   aux_req      in   1       aux request, this cycle
//   aux_we       in   1       1=write, 0=read
//   aux_lock     in   1       keep the grant on the following cycles (read-modify-write)
//   aux_addr     in   ADDR_W  aux address
//   aux_wdata    in   DATA_W  aux write data
//   aux_gnt      out  1       aux request accepted this cycle (combinational)
//   aux_rvalid   out  1       aux_rdata valid (reads only)
//   aux_rdata    out  DATA_W  aux read data
//   mem_addr     out  ADDR_W  to bram addr_b
//   mem_wdata    out  DATA_W  to bram data_b
//   mem_we       out  1       to bram we_b
//   mem_q        in   DATA_W  from bram q_b
//   aux_forced   out  1       registered 1-cycle pulse when a starvation-forced grant occurs
// BEHAVIOUR
//   - rst asserted: state=ARB, starve_cnt=0, lock_cnt=0, read tracker cleared; all gnt/rvalid/
//     mem_we/aux_forced=0; rdata, mem_addr, mem_wdata=0. Grants are blocked while rst is high.
//   - Grants: one accepted request per cycle. The granted request drives mem_addr/mem_wdata.
//     mem_we = aux_gnt & aux_we. With no grant: mem_addr holds 0 and mem_we=0.
//   - Reads: the tracker is a shift register of {valid, owner}, RD_LATENCY deep. For a read
//     granted in cycle N, the owner's rvalid=1 in cycle N+RD_LATENCY and rdata=mem_q in that
//     cycle. Writes never produce an rvalid. Back-to-back reads are allowed; throughput is 1/cycle.
//   - FSM states:
//     ARB: vga_req -> vga_gnt; else aux_req -> aux_gnt.
//          Go to LOCK if aux is granted with aux_lock=1.
//          Go to FORCE if starve_cnt reaches STARVE_LIMIT-1 while aux is being denied.
//     FORCE: aux_gnt=aux_req; vga_gnt=0 even when vga_req=1 (that VGA beat is dropped).
//          aux_forced pulses. Next state is LOCK if aux_lock=1, else ARB.
//     LOCK: aux_gnt=aux_req; vga denied. lock_cnt increments per cycle.
//          Return to ARB when aux_req=0, aux_lock=0, or lock_cnt=LOCK_MAX-1.
//          lock_cnt clears on exit.
//   - starve_cnt: increments when aux_req=1 and aux_gnt=0. Clears when aux is granted or
//     aux_req=0. Saturates at STARVE_LIMIT.
//   - Simultaneous requests in ARB with starve_cnt < limit: VGA wins.
//   - Address/data are not checked (full 16-bit range); address wrap is the BRAM's concern.
//   - rst mid-operation: in-flight reads are discarded (no rvalid after reset) and LOCK is abandoned.
// STRUCTURE
//   - Package bram_arb_pkg: state encoding (ARB, FORCE, LOCK) and owner encoding
//     (OWN_VGA=0, OWN_AUX=1).
//   - Sub-module arb_rd_tracker: parameterised RD_LATENCY pipeline of {valid, owner}
//     with async clear.
//   - Top level holds the FSM, the counters and the output muxing.
// TESTING
//   - Reset: rst=1 with both requests high -> no gnt, mem_we=0, no rvalid.
//     Release rst -> vga_gnt in the first cycle.
//   - VGA reads 0x0100..0x0103 back-to-back, BRAM preloaded with 0xA000+addr
//     -> vga_rvalid 4 consecutive cycles, RD_LATENCY after each grant, data 0xA100..0xA103.
//   - Contention: vga_req and aux_req held high, STARVE_LIMIT=8 -> aux denied 8 cycles,
//     forced aux_gnt on the 9th with aux_forced=1 and vga_gnt=0, then VGA resumes.
//   - Lock: aux read 0x0200 with aux_lock=1, then write 0x0200=0x1234 while vga_req is high
//     -> VGA denied for both cycles, mem_we=1 in cycle 2; a VGA read of 0x0200 afterwards
//     returns 0x1234.
//   - Lock bound: aux_lock held for 10 cycles, LOCK_MAX=4 -> exactly 4 aux grants,
//     then vga_gnt.
//   - Reset mid-read: rst asserted one cycle after an aux read grant -> aux_rvalid never
//     asserts, and the state is ARB after release.

Source files
------------

// File: rtl/bram_arb_pkg.sv
// Shared types for the BRAM port-B arbiter: FSM state encoding and read-owner encoding.
package bram_arb_pkg;

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_FORCE = 2'd1,
        ST_LOCK  = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_VGA = 1'b0,
        OWN_AUX = 1'b1
    } owner_e;

endpackage

// File: rtl/arb_rd_tracker.sv
// Read-return tracker: a RD_LATENCY-deep pipeline of {valid, owner} that lines up
// each granted read with the cycle its data appears on the BRAM q port.
module arb_rd_tracker #(
    parameter int RD_LATENCY = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic in_owner,
    output logic out_valid,
    output logic out_owner
);

    logic [RD_LATENCY-1:0] valid_sr;
    logic [RD_LATENCY-1:0] owner_sr;

    // Clearing valid on reset discards every in-flight read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_sr <= '0;
            owner_sr <= '0;
        end else begin
            valid_sr[0] <= in_valid;
            owner_sr[0] <= in_owner;
            for (int i = 1; i < RD_LATENCY; i++) begin
                valid_sr[i] <= valid_sr[i-1];
                owner_sr[i] <= owner_sr[i-1];
            end
        end
    end

    assign out_valid = valid_sr[RD_LATENCY-1];
    assign out_owner = owner_sr[RD_LATENCY-1];

endmodule

// File: rtl/bram_portb_arbiter.sv
// Shares BRAM port B between the VGA scanout reader (priority) and an aux master,
// with a starvation guard that forces one aux grant and a bounded aux lock for RMW.
module bram_portb_arbiter
    import bram_arb_pkg::*;
#(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int RD_LATENCY   = 1,
    parameter int STARVE_LIMIT = 8,
    parameter int LOCK_MAX     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic              vga_gnt,
    output logic              vga_rvalid,
    output logic [DATA_W-1:0] vga_rdata,
    input  logic              aux_req,
    input  logic              aux_we,
    input  logic              aux_lock,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [DATA_W-1:0] aux_wdata,
    output logic              aux_gnt,
    output logic              aux_rvalid,
    output logic [DATA_W-1:0] aux_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_q,
    output logic              aux_forced
);

    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    localparam int LC_W = $clog2(LOCK_MAX + 1);
    localparam logic [SC_W-1:0] STARVE_LAST = SC_W'(STARVE_LIMIT - 1);
    localparam logic [SC_W-1:0] STARVE_SAT  = SC_W'(STARVE_LIMIT);
    localparam logic [LC_W-1:0] LOCK_LAST   = LC_W'(LOCK_MAX - 1);
    // With LOCK_MAX=1 the entry grant already uses the whole lock budget.
    localparam bit LOCK_ALLOWED = (LOCK_MAX > 1);

    arb_state_e      state, state_nxt;
    logic [SC_W-1:0] starve_cnt, starve_nxt;
    logic [LC_W-1:0] lock_cnt, lock_nxt;
    logic            forced_q;
    logic            trk_valid, trk_owner;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        vga_gnt   = 1'b0;
        aux_gnt   = 1'b0;
        state_nxt = state;
        lock_nxt  = lock_cnt;
        if (!rst) begin
            unique case (state)
                ST_ARB: begin
                    if (vga_req)      vga_gnt = 1'b1;
                    else if (aux_req) aux_gnt = 1'b1;
                    if (aux_gnt && aux_lock && LOCK_ALLOWED) begin
                        state_nxt = ST_LOCK;
                        lock_nxt  = LC_W'(1);
                    end else if (aux_req && !aux_gnt && starve_cnt == STARVE_LAST) begin
                        state_nxt = ST_FORCE;
                    end
                end
                ST_FORCE: begin
                    aux_gnt = aux_req;
                    if (aux_gnt && aux_lock && LOCK_ALLOWED) begin
                        state_nxt = ST_LOCK;
                        lock_nxt  = LC_W'(1);
                    end else begin
                        state_nxt = ST_ARB;
                    end
                end
                ST_LOCK: begin
                    aux_gnt = aux_req;
                    if (!aux_req || !aux_lock || lock_cnt >= LOCK_LAST) begin
                        state_nxt = ST_ARB;
                        lock_nxt  = '0;
                    end else begin
                        lock_nxt = lock_cnt + LC_W'(1);
                    end
                end
                default: begin
                    state_nxt = ST_ARB;
                    lock_nxt  = '0;
                end
            endcase
        end
    end

    always_comb begin
        starve_nxt = '0;
        if (aux_req && !aux_gnt)
            starve_nxt = (starve_cnt == STARVE_SAT) ? starve_cnt : starve_cnt + SC_W'(1);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_ARB;
            starve_cnt <= '0;
            lock_cnt   <= '0;
            forced_q   <= 1'b0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
            lock_cnt   <= lock_nxt;
            forced_q   <= (state_nxt == ST_FORCE);
        end
    end

    assign aux_forced = forced_q;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (vga_gnt) begin
            mem_addr = vga_addr;
        end else if (aux_gnt) begin
            mem_addr  = aux_addr;
            mem_wdata = aux_wdata;
            mem_we    = aux_we;
        end
    end

    arb_rd_tracker #(
        .RD_LATENCY(RD_LATENCY)
    ) u_rd_tracker (
        .clk      (clk),
        .rst      (rst),
        .in_valid (vga_gnt | (aux_gnt & ~aux_we)),
        .in_owner (aux_gnt ? OWN_AUX : OWN_VGA),
        .out_valid(trk_valid),
        .out_owner(trk_owner)
    );

    assign vga_rvalid = trk_valid && (trk_owner == OWN_VGA);
    assign aux_rvalid = trk_valid && (trk_owner == OWN_AUX);
    assign vga_rdata  = vga_rvalid ? mem_q : '0;
    assign aux_rdata  = aux_rvalid ? mem_q : '0;

endmodule

// File: tb/tb_bram_portb_arbiter.sv
// Directed bench: grants checked in-cycle by the stimulus, read returns checked by a
// scoreboard monitor against a small behavioural BRAM preloaded with 0xA000+addr.
module tb_bram_portb_arbiter;

    localparam int RD_LAT = 1;

    logic        clk, rst;
    logic        vga_req, vga_gnt, vga_rvalid;
    logic [15:0] vga_addr, vga_rdata;
    logic        aux_req, aux_we, aux_lock, aux_gnt, aux_rvalid, aux_forced;
    logic [15:0] aux_addr, aux_wdata, aux_rdata;
    logic [15:0] mem_addr, mem_wdata, mem_q;
    logic        mem_we;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    typedef struct {
        logic        owner;
        logic [15:0] data;
        int          due;
    } exp_t;
    exp_t sb[$];

    bram_portb_arbiter #(
        .ADDR_W(16), .DATA_W(16), .RD_LATENCY(RD_LAT), .STARVE_LIMIT(8), .LOCK_MAX(4)
    ) dut (
        .clk(clk), .rst(rst),
        .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
        .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
        .aux_req(aux_req), .aux_we(aux_we), .aux_lock(aux_lock),
        .aux_addr(aux_addr), .aux_wdata(aux_wdata), .aux_gnt(aux_gnt),
        .aux_rvalid(aux_rvalid), .aux_rdata(aux_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_q(mem_q),
        .aux_forced(aux_forced)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Behavioural BRAM: unwritten locations read as 0xA000+addr, one-cycle read latency.
    logic [15:0] wr_mem [int];
    always @(posedge clk) begin
        if (mem_we) wr_mem[int'(mem_addr)] = mem_wdata;
        mem_q <= wr_mem.exists(int'(mem_addr)) ? wr_mem[int'(mem_addr)] : 16'hA000 + mem_addr;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cycle);
        end
    endtask

    // Scoreboard monitor: rvalid must appear exactly in the cycle an entry is due.
    always @(negedge clk) begin
        logic got_v, exp_v;
        exp_t e;
        got_v = vga_rvalid | aux_rvalid;
        exp_v = (sb.size() != 0) && (sb[0].due == cycle);
        check("rvalid", got_v, exp_v);
        if (exp_v) begin
            e = sb.pop_front();
            if (got_v) begin
                check("rd_owner", aux_rvalid, e.owner);
                check("rd_data", aux_rvalid ? aux_rdata : vga_rdata, e.data);
            end
        end
    end

    task automatic step(input logic vr, input logic [15:0] va,
                        input logic ar, input logic aw, input logic al,
                        input logic [15:0] aa, input logic [15:0] ad,
                        input logic e_vg, input logic e_ag, input logic e_fc,
                        input logic [15:0] e_data, input logic push, input string name);
        @(posedge clk);
        #1;
        rst = 1'b0;
        vga_req = vr; vga_addr = va;
        aux_req = ar; aux_we = aw; aux_lock = al; aux_addr = aa; aux_wdata = ad;
        #1;
        check({name, " vga_gnt"}, vga_gnt, e_vg);
        check({name, " aux_gnt"}, aux_gnt, e_ag);
        check({name, " mem_we"}, mem_we, e_ag & aw);
        check({name, " mem_addr"}, mem_addr, e_vg ? va : (e_ag ? aa : 16'h0));
        check({name, " aux_forced"}, aux_forced, e_fc);
        if (e_ag && aw) check({name, " mem_wdata"}, mem_wdata, ad);
        if (push && (e_vg || (e_ag && !aw)))
            sb.push_back('{owner: e_ag, data: e_data, due: cycle + RD_LAT});
    endtask

    task automatic idle(input string name);
        step(0, 16'h0, 0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 0, name);
    endtask

    initial begin
        rst = 1'b1;
        vga_req = 1'b1; vga_addr = 16'h0055;
        aux_req = 1'b1; aux_we = 1'b1; aux_lock = 1'b1; aux_addr = 16'h0066; aux_wdata = 16'hBEEF;

        // Reset holds off all grants even with both requesters active.
        @(negedge clk);
        @(negedge clk);
        check("rst vga_gnt", vga_gnt, 0);
        check("rst aux_gnt", aux_gnt, 0);
        check("rst mem_we", mem_we, 0);
        check("rst mem_addr", mem_addr, 0);
        check("rst aux_forced", aux_forced, 0);
        check("rst vga_rdata", vga_rdata, 0);

        // Back-to-back VGA reads starting in the first cycle after reset release.
        for (int i = 0; i < 4; i++)
            step(1, 16'h0100 + 16'(i), 0, 0, 0, 16'h0, 16'h0, 1, 0, 0, 16'hA100 + 16'(i), 1, "vga_burst");
        idle("idle0");

        // Contention: 8 denied aux cycles, forced grant on the 9th, VGA resumes.
        for (int i = 0; i < 8; i++)
            step(1, 16'h0300, 1, 0, 0, 16'h0400, 16'h0, 1, 0, 0, 16'hA300, 1, "contend_vga");
        step(1, 16'h0300, 1, 0, 0, 16'h0400, 16'h0, 0, 1, 1, 16'hA400, 1, "contend_force");
        step(1, 16'h0300, 1, 0, 0, 16'h0400, 16'h0, 1, 0, 0, 16'hA300, 1, "contend_resume");
        idle("idle1");

        // Locked read-modify-write of 0x0200, then VGA reads back the new value.
        step(0, 16'h0000, 1, 0, 1, 16'h0200, 16'h0000, 0, 1, 0, 16'hA200, 1, "lock_rd");
        step(1, 16'h0200, 1, 1, 0, 16'h0200, 16'h1234, 0, 1, 0, 16'h0000, 1, "lock_wr");
        step(1, 16'h0200, 0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h1234, 1, "lock_readback");
        idle("idle2");

        // Lock bound: aux_lock held 10 cycles yields exactly 4 aux grants.
        step(0, 16'h0000, 1, 0, 1, 16'h0500, 16'h0, 0, 1, 0, 16'hA500, 1, "bound_enter");
        for (int i = 1; i < 4; i++)
            step(1, 16'h0600, 1, 0, 1, 16'h0500 + 16'(i), 16'h0, 0, 1, 0, 16'hA500 + 16'(i), 1, "bound_lock");
        for (int i = 0; i < 6; i++)
            step(1, 16'h0600 + 16'(i), 1, 0, 1, 16'h0510, 16'h0, 1, 0, 0, 16'hA600 + 16'(i), 1, "bound_vga");
        idle("idle3");

        // Reset one cycle after a locked aux read grant: the read is dropped and LOCK abandoned.
        step(0, 16'h0000, 1, 0, 1, 16'h0700, 16'h0, 0, 1, 0, 16'hA700, 0, "rstmid_rd");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("rstmid aux_rvalid", aux_rvalid, 0);
        check("rstmid aux_gnt", aux_gnt, 0);
        @(negedge clk);
        check("rstmid aux_rvalid hold", aux_rvalid, 0);
        step(1, 16'h0800, 1, 0, 1, 16'h0801, 16'h0, 1, 0, 0, 16'hA800, 1, "rstmid_arb");
        idle("idle4");
        idle("idle5");

        check("scoreboard drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
